alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//   Execute stage directly downstream of the ALU opcode decoder: latches one
//   operation (4-bit alu_ctrl plus rd/rs operands) and returns an 8-bit result
//   with carry/zero flags. Handshakes on both sides (valid/ready in, valid/ready out).
//   Single-cycle ops take 1 cycle. Shifts are iterative, 1 bit/cycle.
//   The execute unit feeds register-file writeback and the flag register.
// PARAMETERS
//   DATA_W   8   operand/result width
//   SHAMT_W  3   shift-amount width, taken from rs_data[SHAMT_W-1:0]
// PORTS
//   clock      in   1       system clock, all state on rising edge
//   reset_n    in   1       asynchronous reset, active low
//   in_valid   in   1       operation presented on alu_ctrl/rd_data/rs_data
//   in_ready   out  1       unit can accept an operation (1 only in IDLE)
//   alu_ctrl   in   4       operation code from the decoder
//   rd_data    in   DATA_W  destination operand / shift source
//   rs_data    in   DATA_W  source operand / shift amount
//   out_valid  out  1       result/carry/zero valid, held until out_ready
//   out_ready  in   1       consumer accepts result
//   result     out  DATA_W  operation result (registered)
//   carry      out  1       carry/borrow/shifted-out bit (registered)
//   zero       out  1       result == 0 (registered)
// BEHAVIOUR
//   Operation codes (alu_ctrl):
//     0000 ADD rd+rs, carry = bit 8 of the 9-bit sum
//     1000 SUB rd-rs, carry = borrow (1 when rd < rs, unsigned)
//     0001 AND, 0010 OR, 0011 XOR, 0100 NOT rd: carry=0
//     0101 SLL, 0110 SRL (zero fill), 0111 SRA (sign fill) of rd
//       by rs[SHAMT_W-1:0]; carry = last bit shifted out (0 when amount 0)
//     other codes: result = rd_data, carry = 0 (no error signalled)
//   Reset (async, reset_n=0): state=IDLE, result=0, carry=0, zero=0,
//     out_valid=0, in_ready=1 immediately; any operation in flight is
//     discarded and nothing is emitted for it.
//   FSM states IDLE, SHIFT, DONE.
//     IDLE:  in_ready=1. On in_valid: latch operands.
//       Non-shift op: result/carry/zero computed and registered -> DONE.
//       Shift op with amount 0: result=rd, carry=0 -> DONE.
//       Shift op with amount>0: shreg=rd, cnt=amount -> SHIFT.
//     SHIFT: in_ready=0. Each cycle shreg shifts 1 bit, carry takes the bit
//       shifted out, cnt decrements; when cnt reaches 0, result=shreg -> DONE.
//       Inputs ignored while in SHIFT.
//     DONE: out_valid=1. result/carry/zero stable until out_ready=1.
//       On out_ready -> IDLE.
//   Latency, in_valid accept edge to out_valid high:
//     1 cycle for non-shift ops; 1+amount cycles for shifts.
//   Throughput: no accept in the same cycle as the out_ready handoff. A new op
//     is accepted no earlier than 1 cycle after the result is taken.
//   zero is always derived from the final registered result; it is never
//     derived from intermediate shreg values.
//   Width: all arithmetic is modulo 2^DATA_W. Wrap-around is reported only
//     through carry.
// TESTING
//   1 reset_n low mid-SHIFT (SLL amount 7, cycle 3) -> out_valid=0, in_ready=1, result=0
//       asynchronously; the next op behaves normally.
//   2 ADD rd=8'hF0 rs=8'h10 -> after 1 cycle result=8'h00, carry=1, zero=1.
//     SUB 8'h05-8'h07 -> result=8'hFE, carry=1, zero=0.
//   3 SRA rd=8'h81 amount 3 -> out_valid 4 cycles after accept;
//     result=8'hF0, carry=0. SLL 8'h81 amount 1 -> result=8'h02, carry=1.
//   4 Shift amount 0 (SRL rd=8'h5A rs=8'h08) -> 1-cycle latency,
//     result=8'h5A, carry=0 (only rs[2:0] used).
//   5 Hold out_ready=0 for 5 cycles in DONE -> result/flags stable,
//     in_ready=0, and new in_valid is ignored. After out_ready, IDLE;
//     the next op is accepted on the following edge.
//   6 alu_ctrl=4'b1111 rd=8'h3C -> result=8'h3C, carry=0, zero=0;
//     random stream checked against a reference model.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle logic/arithmetic ops plus iterative 1-bit/cycle shifts,
// with a valid/ready handshake on both the operation input and the result output.
module alu_exec_unit #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] rs_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic [SHAMT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]          sop, sop_nxt;
    logic [DATA_W-1:0]   result_nxt;
    logic                carry_nxt, zero_nxt;

    logic [DATA_W:0]     sum, diff;
    logic [DATA_W-1:0]   alu_res, step;
    logic                alu_c, step_c, is_shift;
    logic [SHAMT_W-1:0]  amt;

    assign amt      = rs_data[SHAMT_W-1:0];
    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign sum      = {1'b0, rd_data} + {1'b0, rs_data};
    // Top bit of the widened unsigned difference is the borrow.
    assign diff     = {1'b0, rd_data} - {1'b0, rs_data};

    // Single-cycle result; shift codes land here only when the amount is 0.
    always_comb begin
        alu_res = rd_data;
        alu_c   = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
            OP_SUB: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
            OP_AND: alu_res = rd_data & rs_data;
            OP_OR:  alu_res = rd_data | rs_data;
            OP_XOR: alu_res = rd_data ^ rs_data;
            OP_NOT: alu_res = ~rd_data;
            default: ;
        endcase
    end

    // One-bit shift step; sop holds alu_ctrl[1:0] of the latched shift op.
    always_comb begin
        step   = shreg;
        step_c = 1'b0;
        case (sop)
            2'b01: begin step = {shreg[DATA_W-2:0], 1'b0};          step_c = shreg[DATA_W-1]; end
            2'b10: begin step = {1'b0, shreg[DATA_W-1:1]};          step_c = shreg[0];        end
            2'b11: begin step = {shreg[DATA_W-1], shreg[DATA_W-1:1]}; step_c = shreg[0];      end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        sop_nxt    = sop;
        result_nxt = result;
        carry_nxt  = carry;
        zero_nxt   = zero;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (amt != '0)) begin
                        shreg_nxt = rd_data;
                        cnt_nxt   = amt;
                        sop_nxt   = alu_ctrl[1:0];
                        state_nxt = SHIFT;
                    end else begin
                        result_nxt = alu_res;
                        carry_nxt  = alu_c;
                        zero_nxt   = (alu_res == '0);
                        state_nxt  = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_nxt = step;
                carry_nxt = step_c;
                cnt_nxt   = cnt - SHAMT_W'(1);
                // Final step publishes the shifted value together with its flags.
                if (cnt == SHAMT_W'(1)) begin
                    result_nxt = step;
                    zero_nxt   = (step == '0);
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            sop    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
            sop    <= sop_nxt;
            result <= result_nxt;
            carry  <= carry_nxt;
            zero   <= zero_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
endmodule
